controle_multiciclo: RTL and testbench
======================================

Name: controle_multiciclo

Overview:
- Multicycle control unit for the 8-bit nRisc datapath. It is the issuing end of the ALU interface: it drives ULAOp and the operand-mux selects, and consumes Zero for branch resolution.
- Fetches instructions through a shared memory with a ready handshake, sequences execute, memory and writeback, and counts retired instructions.

Parameters:
- LARGURA_CONT, 8, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces the FSM to BUSCA immediately.
- Instrucao  in  8  current IR contents; opcode = Instrucao[7:5].
- Zero  in  1  ALU Zero flag.
- MemPronta  in  1  memory completes the current read/write this cycle.
- ULAOp  out  2  00 soma, 01 subtracao, 10 slt; 11 is never driven.
- OrigemA  out  1  0 = PC, 1 = register A.
- OrigemB  out  2  00 reg B, 01 constant 1, 10 sign-extended imm, 11 branch offset.
- PCFonte  out  2  00 ALU result, 01 registered ALU output (branch target).
- EscrevePC, EscreveIR, LeMem, EscreveMem, IouD, EscreveReg, MemParaReg  out  1 each  datapath strobes and selects.
- Parado  out  1  halted.
- Estado  out  4  current state encoding (debug).
- Instrucoes  out  LARGURA_CONT  retired-instruction count.

Behaviour:
- Opcodes: 000 add, 001 sub, 010 slt, 011 lw, 100 sw, 101 beq, 110 addi, 111 halt.
- Outputs not listed for a state are 0. Outputs are Moore from state, except strobes gated by MemPronta or Zero.

States and transitions:
- BUSCA(0): LeMem=1, IouD=0, OrigemA=0, OrigemB=01, ULAOp=00, PCFonte=00.
  - EscreveIR and EscrevePC equal MemPronta.
  - Advances to DECODIFICA only when MemPronta=1; otherwise holds with no writes.
- DECODIFICA(1): OrigemA=0, OrigemB=11, ULAOp=00 (precomputes branch target). Next state:
  - 000/001/010 -> EXEC_R
  - 011/100/110 -> CALC_END
  - 101 -> DESVIO
  - 111 -> PARADO
- EXEC_R(2): OrigemA=1, OrigemB=00, ULAOp=opcode[1:0] (00/01/10) -> ESCRITA_R.
- ESCRITA_R(3): EscreveReg=1, MemParaReg=0 -> BUSCA; instruction retires.
- CALC_END(4): OrigemA=1, OrigemB=10, ULAOp=00. lw -> LE_MEM; sw -> GRAVA_MEM; addi -> ESCRITA_R.
- LE_MEM(5): LeMem=1, IouD=1. Holds until MemPronta=1, then -> ESCRITA_MEM.
- ESCRITA_MEM(6): EscreveReg=1, MemParaReg=1 -> BUSCA; retires.
- GRAVA_MEM(7): EscreveMem=1, IouD=1. Holds until MemPronta=1, then -> BUSCA; retires on that cycle.
- DESVIO(8): OrigemA=1, OrigemB=00, ULAOp=01, PCFonte=01, EscrevePC=Zero -> BUSCA; retires whether taken or not.
- PARADO(9): Parado=1, all strobes 0; terminal until reset.
- Encodings 10-15 are illegal and recover to BUSCA on the next edge with all strobes 0.

Counter and reset:
- Instrucoes increments by 1 on each retiring edge and wraps from 2^LARGURA_CONT-1 to 0.
- Reset low: state=BUSCA, Instrucoes=0, Estado=0, Parado=0.
- While reset is low, every strobe (EscrevePC, EscreveIR, LeMem, EscreveMem, EscreveReg) is forced 0 regardless of state.
- Reset asserted mid-instruction (e.g. in LE_MEM) aborts with no further writes. After release, the first edge evaluates BUSCA.
- Zero and MemPronta are sampled only in the states listed; they are ignored elsewhere.

Latency (cycles with MemPronta=1 throughout):
- R-type and addi: 4.
- beq: 3.
- lw: 5.
- sw: 4.

Test Plan:
- Reset low, then release, Instrucao=8'b000_xxxxx (add), MemPronta=1 -> Estado 0,1,2,3,0; ULAOp=00 in EXEC_R; EscreveReg=1 in ESCRITA_R; Instrucoes 0->1.
- sub (001) then slt (010) -> ULAOp=01 then 10 in EXEC_R; Instrucoes=2; ULAOp never 11 in any state.
- lw (011) with MemPronta held 0 for 3 cycles in LE_MEM -> Estado stays 5 for 3 cycles with LeMem=1, IouD=1, then 6 with MemParaReg=1, EscreveReg=1.
- beq (101) with Zero=1 -> DESVIO drives EscrevePC=1, PCFonte=01. Repeat with Zero=0 -> EscrevePC=0. Instrucoes increments in both cases.
- halt (111) -> Estado=9, Parado=1, all strobes 0 for 20 cycles. Then reset low -> Estado=0, Parado=0, Instrucoes=0.
- LARGURA_CONT=2, retire 5 adds -> Instrucoes sequence 1,2,3,0,1. Reset pulsed in GRAVA_MEM -> EscreveMem drops the same cycle, asynchronously.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the 8-bit nRisc datapath: sequences fetch/decode/execute,
// drives ALU and mux selects, and counts retired instructions.
module controle_multiciclo #(
    parameter int unsigned LARGURA_CONT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              Instrucao,
    input  logic                    Zero,
    input  logic                    MemPronta,
    output logic [1:0]              ULAOp,
    output logic                    OrigemA,
    output logic [1:0]              OrigemB,
    output logic [1:0]              PCFonte,
    output logic                    EscrevePC,
    output logic                    EscreveIR,
    output logic                    LeMem,
    output logic                    EscreveMem,
    output logic                    IouD,
    output logic                    EscreveReg,
    output logic                    MemParaReg,
    output logic                    Parado,
    output logic [3:0]              Estado,
    output logic [LARGURA_CONT-1:0] Instrucoes
);

    typedef enum logic [3:0] {
        BUSCA       = 4'd0,
        DECODIFICA  = 4'd1,
        EXEC_R      = 4'd2,
        ESCRITA_R   = 4'd3,
        CALC_END    = 4'd4,
        LE_MEM      = 4'd5,
        ESCRITA_MEM = 4'd6,
        GRAVA_MEM   = 4'd7,
        DESVIO      = 4'd8,
        PARADO      = 4'd9
    } estado_t;

    estado_t                 state, next_state;
    logic [2:0]              opcode;
    logic                    retire;
    logic                    pc_wr, ir_wr, mem_rd, mem_wr, reg_wr;
    logic [LARGURA_CONT-1:0] count;
    logic                    unused_bits;

    assign opcode      = Instrucao[7:5];
    assign unused_bits = ^Instrucao[4:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BUSCA;
            count <= '0;
        end else begin
            state <= next_state;
            if (retire)
                count <= count + LARGURA_CONT'(1);
        end
    end

    always_comb begin
        next_state = BUSCA;
        retire     = 1'b0;
        ULAOp      = 2'b00;
        OrigemA    = 1'b0;
        OrigemB    = 2'b00;
        PCFonte    = 2'b00;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        IouD       = 1'b0;
        reg_wr     = 1'b0;
        MemParaReg = 1'b0;
        Parado     = 1'b0;
        case (state)
            BUSCA: begin
                mem_rd     = 1'b1;
                OrigemB    = 2'b01;
                ir_wr      = MemPronta;
                pc_wr      = MemPronta;
                next_state = MemPronta ? DECODIFICA : BUSCA;
            end
            DECODIFICA: begin
                OrigemB = 2'b11;
                case (opcode)
                    3'b000, 3'b001, 3'b010: next_state = EXEC_R;
                    3'b011, 3'b100, 3'b110: next_state = CALC_END;
                    3'b101:                 next_state = DESVIO;
                    default:                next_state = PARADO;
                endcase
            end
            EXEC_R: begin
                OrigemA    = 1'b1;
                ULAOp      = opcode[1:0];
                next_state = ESCRITA_R;
            end
            ESCRITA_R: begin
                reg_wr = 1'b1;
                retire = 1'b1;
            end
            CALC_END: begin
                OrigemA = 1'b1;
                OrigemB = 2'b10;
                case (opcode)
                    3'b011:  next_state = LE_MEM;
                    3'b100:  next_state = GRAVA_MEM;
                    3'b110:  next_state = ESCRITA_R;
                    default: next_state = BUSCA;
                endcase
            end
            LE_MEM: begin
                mem_rd     = 1'b1;
                IouD       = 1'b1;
                next_state = MemPronta ? ESCRITA_MEM : LE_MEM;
            end
            ESCRITA_MEM: begin
                reg_wr     = 1'b1;
                MemParaReg = 1'b1;
                retire     = 1'b1;
            end
            GRAVA_MEM: begin
                mem_wr     = 1'b1;
                IouD       = 1'b1;
                retire     = MemPronta;
                next_state = MemPronta ? BUSCA : GRAVA_MEM;
            end
            DESVIO: begin
                OrigemA = 1'b1;
                ULAOp   = 2'b01;
                PCFonte = 2'b01;
                pc_wr   = Zero;
                retire  = 1'b1;
            end
            PARADO: begin
                Parado     = 1'b1;
                next_state = PARADO;
            end
            default: next_state = BUSCA;
        endcase
    end

    // Reset parks the FSM in BUSCA, whose Moore strobes would otherwise be live.
    assign EscrevePC  = pc_wr  & reset;
    assign EscreveIR  = ir_wr  & reset;
    assign LeMem      = mem_rd & reset;
    assign EscreveMem = mem_wr & reset;
    assign EscreveReg = reg_wr & reset;

    assign Estado     = state;
    assign Instrucoes = count;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle expected outputs derived from the
// state table, plus a 2-bit-counter instance to observe wraparound.
module tb_controle_multiciclo;

    localparam int S_BUSCA = 0, S_DEC = 1, S_EXEC_R = 2, S_ESC_R = 3, S_CALC = 4,
                   S_LE = 5, S_ESC_MEM = 6, S_GRAVA = 7, S_DESVIO = 8, S_PARADO = 9;

    typedef struct packed {
        logic [3:0] estado;
        logic [1:0] ulaop;
        logic       origem_a;
        logic [1:0] origem_b;
        logic [1:0] pc_fonte;
        logic [6:0] strobes;   // EscrevePC, EscreveIR, LeMem, EscreveMem, IouD, EscreveReg, MemParaReg
        logic       parado;
        logic [7:0] count;
        logic [1:0] count2;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] Instrucao = '0;
    logic       Zero = 1'b0;
    logic       MemPronta = 1'b0;

    logic [1:0] ULAOp, OrigemB, PCFonte;
    logic       OrigemA, EscrevePC, EscreveIR, LeMem, EscreveMem, IouD, EscreveReg, MemParaReg, Parado;
    logic [3:0] Estado;
    logic [7:0] Instrucoes;

    logic [1:0] d2_ulaop, d2_origem_b, d2_pc_fonte;
    logic       d2_origem_a, d2_pc_wr, d2_ir_wr, d2_mem_rd, d2_mem_wr, d2_iord, d2_reg_wr, d2_mtr, d2_parado;
    logic [3:0] d2_estado;
    logic [1:0] d2_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    controle_multiciclo dut (
        .clock(clock), .reset(reset), .Instrucao(Instrucao), .Zero(Zero), .MemPronta(MemPronta),
        .ULAOp(ULAOp), .OrigemA(OrigemA), .OrigemB(OrigemB), .PCFonte(PCFonte),
        .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .LeMem(LeMem), .EscreveMem(EscreveMem),
        .IouD(IouD), .EscreveReg(EscreveReg), .MemParaReg(MemParaReg), .Parado(Parado),
        .Estado(Estado), .Instrucoes(Instrucoes)
    );

    controle_multiciclo #(.LARGURA_CONT(2)) dut2 (
        .clock(clock), .reset(reset), .Instrucao(Instrucao), .Zero(Zero), .MemPronta(MemPronta),
        .ULAOp(d2_ulaop), .OrigemA(d2_origem_a), .OrigemB(d2_origem_b), .PCFonte(d2_pc_fonte),
        .EscrevePC(d2_pc_wr), .EscreveIR(d2_ir_wr), .LeMem(d2_mem_rd), .EscreveMem(d2_mem_wr),
        .IouD(d2_iord), .EscreveReg(d2_reg_wr), .MemParaReg(d2_mtr), .Parado(d2_parado),
        .Estado(d2_estado), .Instrucoes(d2_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t spec_row(input int st, input logic [2:0] opc, input bit mp, input bit z);
        exp_t e;
        e = '0;
        e.estado = 4'(st);
        case (st)
            S_BUSCA:   begin e.origem_b = 2'b01; e.strobes = {mp, mp, 5'b10000}; end
            S_DEC:     e.origem_b = 2'b11;
            S_EXEC_R:  begin e.origem_a = 1'b1; e.ulaop = opc[1:0]; end
            S_ESC_R:   e.strobes = 7'b0000010;
            S_CALC:    begin e.origem_a = 1'b1; e.origem_b = 2'b10; end
            S_LE:      e.strobes = 7'b0010100;
            S_ESC_MEM: e.strobes = 7'b0000011;
            S_GRAVA:   e.strobes = 7'b0001100;
            S_DESVIO:  begin e.origem_a = 1'b1; e.ulaop = 2'b01; e.pc_fonte = 2'b01;
                             e.strobes = {z, 6'b000000}; end
            S_PARADO:  e.parado = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs, queue expectation, compare, cross the rising edge.
    task automatic step(input int st, input logic [2:0] opc, input bit mp, input bit z, input bit retire);
        exp_t e;
        MemPronta = mp;
        Zero      = z;
        e = spec_row(st, opc, mp, z);
        e.count  = 8'(exp_count % 256);
        e.count2 = 2'(exp_count % 4);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        check("estado", 32'(Estado), 32'(e.estado));
        check("ulaop", 32'(ULAOp), 32'(e.ulaop));
        check("ulaop_not3", 32'(ULAOp == 2'b11), 32'd0);
        check("origem", {27'd0, OrigemA, OrigemB, PCFonte}, {27'd0, e.origem_a, e.origem_b, e.pc_fonte});
        check("strobes", {25'd0, EscrevePC, EscreveIR, LeMem, EscreveMem, IouD, EscreveReg, MemParaReg},
              32'(e.strobes));
        check("parado", 32'(Parado), 32'(e.parado));
        check("contador", 32'(Instrucoes), 32'(e.count));
        check("contador2", 32'(d2_count), 32'(e.count2));
        @(negedge clock);
        if (retire) exp_count++;
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic instr(input logic [2:0] opc, input bit z, input int fetch_stall, input int mem_stall);
        Instrucao = {opc, 5'($urandom)};
        repeat (fetch_stall) step(S_BUSCA, opc, 1'b0, rb(), 1'b0);
        step(S_BUSCA, opc, 1'b1, rb(), 1'b0);
        step(S_DEC, opc, rb(), rb(), 1'b0);
        case (opc)
            3'b000, 3'b001, 3'b010: begin
                step(S_EXEC_R, opc, rb(), rb(), 1'b0);
                step(S_ESC_R, opc, rb(), rb(), 1'b1);
            end
            3'b011: begin
                step(S_CALC, opc, rb(), rb(), 1'b0);
                repeat (mem_stall) step(S_LE, opc, 1'b0, rb(), 1'b0);
                step(S_LE, opc, 1'b1, rb(), 1'b0);
                step(S_ESC_MEM, opc, rb(), rb(), 1'b1);
            end
            3'b100: begin
                step(S_CALC, opc, rb(), rb(), 1'b0);
                repeat (mem_stall) step(S_GRAVA, opc, 1'b0, rb(), 1'b0);
                step(S_GRAVA, opc, 1'b1, rb(), 1'b1);
            end
            3'b110: begin
                step(S_CALC, opc, rb(), rb(), 1'b0);
                step(S_ESC_R, opc, rb(), rb(), 1'b1);
            end
            3'b101: step(S_DESVIO, opc, rb(), z, 1'b1);
            default: repeat (20) step(S_PARADO, opc, rb(), rb(), 1'b0);
        endcase
    endtask

    // Called at a falling edge; asserts reset, checks the async effect, releases at the next falling edge.
    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_estado", 32'(Estado), 32'd0);
        check("rst_strobes", {27'd0, EscrevePC, EscreveIR, LeMem, EscreveMem, EscreveReg}, 32'd0);
        check("rst_parado", 32'(Parado), 32'd0);
        check("rst_contador", 32'(Instrucoes), 32'd0);
        check("rst_contador2", 32'(d2_count), 32'd0);
        exp_count = 0;
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        apply_reset();

        instr(3'b000, 1'b0, 0, 0);   // add
        instr(3'b001, 1'b0, 0, 0);   // sub
        instr(3'b010, 1'b0, 0, 0);   // slt
        instr(3'b110, 1'b0, 0, 0);   // addi
        instr(3'b011, 1'b0, 0, 3);   // lw, 3 wait cycles
        instr(3'b100, 1'b0, 0, 1);   // sw, 1 wait cycle
        instr(3'b101, 1'b1, 0, 0);   // beq taken
        instr(3'b101, 1'b0, 0, 0);   // beq not taken
        instr(3'b000, 1'b0, 2, 0);   // add with fetch stall

        apply_reset();
        repeat (5) instr(3'b000, 1'b0, 0, 0);
        check("wrap_final", 32'(d2_count), 32'd1);
        check("count8_final", 32'(Instrucoes), 32'd5);

        // Reset asserted while a store is waiting on memory
        Instrucao = 8'b100_00000;
        step(S_BUSCA, 3'b100, 1'b1, 1'b0, 1'b0);
        step(S_DEC, 3'b100, 1'b0, 1'b0, 1'b0);
        step(S_CALC, 3'b100, 1'b0, 1'b0, 1'b0);
        step(S_GRAVA, 3'b100, 1'b0, 1'b0, 1'b0);
        MemPronta = 1'b0;
        #1;
        check("grava_pre_rst", 32'(EscreveMem), 32'd1);
        apply_reset();
        check("grava_pos_rst", 32'(EscreveMem), 32'd0);

        instr(3'b111, 1'b0, 0, 0);   // halt, 20 cycles parked
        apply_reset();
        instr(3'b000, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
